// File: rtl/traffic_phase_controller.sv
// Timed phase sequencer for a two-road junction with an on-request walk phase.
// Each phase dwells for a programmable number of enabled clock ticks; lamp
// outputs are a pure decode of the registered phase, and the phase code is
// exposed on the phase port so the sequence can be observed directly.
`timescale 1ns/1ps
module traffic_phase_controller #(
    parameter int CNT_W            = 4,
    parameter int MAIN_GREEN_TICKS = 8,
    parameter int SIDE_GREEN_TICKS = 6,
    parameter int YELLOW_TICKS     = 2,
    parameter int ALLRED_TICKS     = 1,
    parameter int PED_TICKS        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        AR1    = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        AR2    = 3'd5,
        WALK   = 3'd6,
        UNUSED = 3'd7
    } phase_t;

    localparam logic [2:0] RED    = 3'b000;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;

    phase_t             state_q, state_d, nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ped_pending_q, ped_pending_d;
    logic               enter_walk;

    // Reload value for the dwell counter: duration of the phase minus one.
    function automatic logic [CNT_W-1:0] dwell(input phase_t p);
        logic [CNT_W-1:0] d;
        d = CNT_W'(ALLRED_TICKS - 1);
        case (p)
            MAIN_G:  d = CNT_W'(MAIN_GREEN_TICKS - 1);
            MAIN_Y:  d = CNT_W'(YELLOW_TICKS - 1);
            SIDE_G:  d = CNT_W'(SIDE_GREEN_TICKS - 1);
            SIDE_Y:  d = CNT_W'(YELLOW_TICKS - 1);
            WALK:    d = CNT_W'(PED_TICKS - 1);
            default: d = CNT_W'(ALLRED_TICKS - 1);
        endcase
        return d;
    endfunction

    // State, dwell counter, pending request and walk acknowledge registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= AR2;
            cnt_q         <= CNT_W'(ALLRED_TICKS - 1);
            ped_pending_q <= 1'b0;
            ped_ack       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ped_pending_q <= ped_pending_d;
            ped_ack       <= enter_walk;
        end
    end

    // Next phase and dwell count; the unused code recovers to AR2 unconditionally
    // so a corrupted state can never stall with enable low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nxt        = state_q;
        enter_walk = 1'b0;
        if (state_q == UNUSED) begin
            state_d = AR2;
            cnt_d   = dwell(AR2);
        end else if (enable) begin
            if (cnt_q == '0) begin
                case (state_q)
                    MAIN_G:  nxt = MAIN_Y;
                    MAIN_Y:  nxt = AR1;
                    AR1:     nxt = SIDE_G;
                    SIDE_G:  nxt = SIDE_Y;
                    SIDE_Y:  nxt = AR2;
                    AR2:     nxt = (ped_pending_q | ped_req) ? WALK : MAIN_G;
                    WALK:    nxt = MAIN_G;
                    default: nxt = AR2;
                endcase
                state_d    = nxt;
                cnt_d      = dwell(nxt);
                enter_walk = (nxt == WALK);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // A request arriving on the walk-entry edge wins over the clear.
    always_comb begin
        ped_pending_d = ped_req | (ped_pending_q & ~enter_walk);
    end

    // Lamp, walk and phase decode of the registered state.
    always_comb begin
        main_light = RED;
        side_light = RED;
        walk       = 1'b0;
        phase      = state_q;
        case (state_q)
            MAIN_G:  main_light = GREEN;
            MAIN_Y:  main_light = YELLOW;
            SIDE_G:  side_light = GREEN;
            SIDE_Y:  side_light = YELLOW;
            WALK:    walk       = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: expected per-cycle outputs are pushed
// from phase/duration tables and popped as the DUT advances.
`timescale 1ns/1ps
module tb_traffic_phase_controller;

    localparam int W = 11;  // {phase[2:0], main[2:0], side[2:0], walk, ack}

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_n2 = 1'b0;
    logic       enable = 1'b1;
    logic       ped_req = 1'b0;

    logic       ped_ack, walk, ped_ack2, walk2;
    logic [2:0] main_light, side_light, phase;
    logic [2:0] main_light2, side_light2, phase2;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // tick values used to build expectations for the DUT under test
    int t_mg = 8, t_my = 2, t_ar = 1, t_sg = 6, t_pd = 4;

    // clock
    always #5 clk = ~clk;

    traffic_phase_controller dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ped_req(ped_req),
        .ped_ack(ped_ack), .main_light(main_light), .side_light(side_light),
        .walk(walk), .phase(phase)
    );

    traffic_phase_controller #(
        .MAIN_GREEN_TICKS(1), .YELLOW_TICKS(1), .ALLRED_TICKS(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n2), .enable(enable), .ped_req(ped_req),
        .ped_ack(ped_ack2), .main_light(main_light2), .side_light(side_light2),
        .walk(walk2), .phase(phase2)
    );

    function automatic logic [W-1:0] exp_word(input logic [2:0] p, input logic ack);
        logic [2:0] m, s;
        logic w;
        m = 3'b000; s = 3'b000; w = 1'b0;
        case (p)
            3'd0: m = 3'b001;
            3'd1: m = 3'b010;
            3'd3: s = 3'b001;
            3'd4: s = 3'b010;
            3'd6: w = 1'b1;
            default: ;
        endcase
        return {p, m, s, w, ack};
    endfunction

    function automatic logic [W-1:0] obs(input logic sel);
        if (sel) return {phase2, main_light2, side_light2, walk2, ped_ack2};
        return {phase, main_light, side_light, walk, ped_ack};
    endfunction

    function automatic string fmt(input logic [W-1:0] v);
        return $sformatf("ph=%0d main=%b side=%b walk=%b ack=%b",
                         v[10:8], v[7:5], v[4:2], v[1], v[0]);
    endfunction

    function automatic void push_phase(input logic [2:0] p, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_word(p, (p == 3'd6) && (i == 0)));
    endfunction

    function automatic void push_round(input bit with_walk);
        push_phase(3'd0, t_mg); push_phase(3'd1, t_my); push_phase(3'd2, t_ar);
        push_phase(3'd3, t_sg); push_phase(3'd4, t_my); push_phase(3'd5, t_ar);
        if (with_walk) push_phase(3'd6, t_pd);
    endfunction

    // driver: apply inputs for the next rising edge, sample at the falling edge
    task automatic step(input logic en, input logic req, input logic sel,
                        output logic [W-1:0] got);
        enable  = en;
        ped_req = req;
        @(negedge clk);
        got = obs(sel);
    endtask

    task automatic test_reset();
        logic [W-1:0] got, exp;
        enable = 1'b1; ped_req = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(exp_word(3'd5, 1'b0));
        exp = exp_q.pop_front(); got = obs(1'b0); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_held: got %s, expected %s", fmt(got), fmt(exp)); end
        rst_n = 1'b1;
        exp_q.push_back(exp_word(3'd5, 1'b0));
        exp = exp_q.pop_front(); got = obs(1'b0); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_release: got %s, expected %s", fmt(got), fmt(exp)); end
    endtask

    task automatic test_no_ped();
        logic [W-1:0] got, exp;
        int n;
        push_round(1'b0); push_round(1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, got);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL no_ped[%0d]: got %s, expected %s", i, fmt(got), fmt(exp)); end
            n_cmp++;
            if (got[7:5] != 3'b000 && got[4:2] != 3'b000) begin
                n_err++; $display("FAIL conflict[%0d]: got main=%b side=%b, required one RED", i, got[7:5], got[4:2]);
            end
        end
    endtask

    task automatic test_ped_pulse();
        logic [W-1:0] got, exp;
        int n;
        push_round(1'b1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            step(1'b1, i == 3, 1'b0, got);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL ped_pulse[%0d]: got %s, expected %s", i, fmt(got), fmt(exp)); end
        end
    endtask

    // request on the AR2 exit edge: walk now, and the same request is re-served next round
    task automatic test_req_on_exit();
        logic [W-1:0] got, exp;
        int n;
        push_round(1'b1); push_round(1'b1); push_round(1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            step(1'b1, i == 20, 1'b0, got);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL req_on_exit[%0d]: got %s, expected %s", i, fmt(got), fmt(exp)); end
        end
    endtask

    // freeze for 5 edges while MAIN_G shows cnt=3, with a request during the freeze
    task automatic test_freeze();
        logic [W-1:0] got, exp;
        int n;
        push_phase(3'd0, t_mg + 5); push_phase(3'd1, t_my); push_phase(3'd2, t_ar);
        push_phase(3'd3, t_sg); push_phase(3'd4, t_my); push_phase(3'd5, t_ar);
        push_phase(3'd6, t_pd);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            step(!(i >= 5 && i <= 9), i == 7, 1'b0, got);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL freeze[%0d]: got %s, expected %s", i, fmt(got), fmt(exp)); end
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] got, exp;
        int n;
        push_phase(3'd0, t_mg); push_phase(3'd1, t_my); push_phase(3'd2, t_ar);
        push_phase(3'd3, t_sg); push_phase(3'd4, 1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            step(1'b1, i == 3, 1'b0, got);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL pre_reset[%0d]: got %s, expected %s", i, fmt(got), fmt(exp)); end
        end
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(exp_word(3'd5, 1'b0));
        exp = exp_q.pop_front(); got = obs(1'b0); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL async_reset: got %s, expected %s", fmt(got), fmt(exp)); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_round(1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, got);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL post_reset[%0d]: got %s, expected %s", i, fmt(got), fmt(exp)); end
        end
    endtask

    task automatic test_params();
        logic [W-1:0] got, exp;
        int n;
        t_mg = 1; t_my = 1; t_ar = 1;
        ped_req = 1'b0;
        @(negedge clk);
        rst_n2 = 1'b1;
        exp_q.push_back(exp_word(3'd5, 1'b0));
        exp = exp_q.pop_front(); got = obs(1'b1); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL params_reset: got %s, expected %s", fmt(got), fmt(exp)); end
        push_round(1'b0); push_round(1'b1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            step(1'b1, i == 14, 1'b1, got);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL params[%0d]: got %s, expected %s", i, fmt(got), fmt(exp)); end
        end
    endtask

    initial begin
        test_reset();
        test_no_ped();
        test_ped_pulse();
        test_req_on_exit();
        test_freeze();
        test_async_reset();
        test_params();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL queue_drain: got %0d leftover entries, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
